// File: rtl/img_stream_pkg.sv
// Shared image-stream parameters and helpers for the window generator and the
// filter kernels that unpack its window bus.
package img_stream_pkg;

   localparam int unsigned IMG_W_DEF = 256;
   localparam int unsigned IMG_H_DEF = 256;
   localparam int unsigned PIX_W_DEF = 8;
   localparam int unsigned KSIZE_DEF = 3;

   // Counter width able to hold 0..n-1 (never narrower than one bit)
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned win_count(input int unsigned w, input int unsigned h,
                                             input int unsigned k);
      return (w - k + 1) * (h - k + 1);
   endfunction

   // Bit offset of window element (r,c); r=0 is the top line, c=0 the leftmost column
   function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned k, input int unsigned pw);
      return (r * k + c) * pw;
   endfunction

endpackage

// File: rtl/window_line_buffer_line_delay.sv
// Enable-gated line delay: dout is the din presented DEPTH enables earlier.
module line_delay #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned W     = 8
) (
   input  logic         clk,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] r_sr [DEPTH];

   // Storage is deliberately unreset; downstream qualification hides stale entries
   always_ff @(posedge clk) begin
      if (en) begin
         r_sr[0] <= din;
         for (int i = 1; i < int'(DEPTH); i++) begin
            r_sr[i] <= r_sr[i-1];
         end
      end
   end

   assign dout = r_sr[DEPTH-1];

endmodule

// File: rtl/window_line_buffer.sv
// Streaming KSIZE x KSIZE neighbourhood generator: raster pixels in, one full
// interior window per registered beat out, with valid/ready backpressure.
module window_line_buffer
   import img_stream_pkg::*;
#(
   parameter int unsigned IMG_W = IMG_W_DEF,
   parameter int unsigned IMG_H = IMG_H_DEF,
   parameter int unsigned PIX_W = PIX_W_DEF,
   parameter int unsigned KSIZE = KSIZE_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic                           s_sof,
   input  logic [PIX_W-1:0]               s_pix,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [KSIZE*KSIZE*PIX_W-1:0]   m_win,
   output logic                           m_last
);

   localparam int unsigned CW    = cnt_w(IMG_W);
   localparam int unsigned RW    = cnt_w(IMG_H);
   localparam int unsigned WIN_W = KSIZE * KSIZE * PIX_W;

   logic [CW-1:0]                  r_col;
   logic [RW-1:0]                  r_row;
   logic                           r_m_valid;
   logic                           r_m_last;
   logic [PIX_W-1:0]               r_win [KSIZE][KSIZE];

   logic [KSIZE-1:0][PIX_W-1:0]    w_tap;
   logic                           w_accept;
   logic                           w_qualify;
   logic                           w_frame_end;
   logic [CW-1:0]                  w_col_eff;
   logic [CW-1:0]                  w_col_nxt;
   logic [RW-1:0]                  w_row_eff;
   logic [RW-1:0]                  w_row_nxt;
   logic [WIN_W-1:0]               w_win_flat;

   assign s_ready  = !r_m_valid || m_ready;
   assign w_accept = s_valid && s_ready;

   // Position of the pixel being accepted; s_sof forces it to (0,0)
   always_comb begin
      w_col_eff   = s_sof ? '0 : r_col;
      w_row_eff   = s_sof ? '0 : r_row;
      w_col_nxt   = w_col_eff + CW'(1);
      w_row_nxt   = w_row_eff;
      w_qualify   = (w_row_eff >= RW'(KSIZE - 1)) && (w_col_eff >= CW'(KSIZE - 1));
      w_frame_end = (w_row_eff == RW'(IMG_H - 1)) && (w_col_eff == CW'(IMG_W - 1));
      if (w_col_eff == CW'(IMG_W - 1)) begin
         w_col_nxt = '0;
         w_row_nxt = (w_row_eff == RW'(IMG_H - 1)) ? '0 : w_row_eff + RW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         r_col <= w_col_nxt;
         r_row <= w_row_nxt;
      end
   end

   // Bottom tap is the live pixel; each line delay supplies the line above
   assign w_tap[KSIZE-1] = s_pix;

   for (genvar g = 0; g < int'(KSIZE) - 1; g++) begin : g_line
      line_delay #(
         .DEPTH (IMG_W),
         .W     (PIX_W)
      ) u_line (
         .clk  (clk),
         .en   (w_accept),
         .din  (w_tap[KSIZE-1-g]),
         .dout (w_tap[KSIZE-2-g])
      );
   end

   // Column taps enter the window from the right on every accepted pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < int'(KSIZE); r++) begin
            for (int c = 0; c < int'(KSIZE); c++) begin
               r_win[r][c] <= '0;
            end
         end
      end else if (w_accept) begin
         for (int r = 0; r < int'(KSIZE); r++) begin
            for (int c = 0; c < int'(KSIZE) - 1; c++) begin
               r_win[r][c] <= r_win[r][c+1];
            end
            r_win[r][KSIZE-1] <= w_tap[r];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
      end else if (w_accept && w_qualify) begin
         r_m_valid <= 1'b1;
         r_m_last  <= w_frame_end;
      end else if (m_ready) begin
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
      end
   end

   always_comb begin
      w_win_flat = '0;
      for (int r = 0; r < int'(KSIZE); r++) begin
         for (int c = 0; c < int'(KSIZE); c++) begin
            w_win_flat[win_idx(r, c, KSIZE, PIX_W) +: PIX_W] = r_win[r][c];
         end
      end
   end

   assign m_win   = w_win_flat;
   assign m_valid = r_m_valid;
   assign m_last  = r_m_last;

endmodule

// File: tb/tb_window_line_buffer.sv
// Scoreboarded bench for window_line_buffer: a K=3 8x6 instance and a K=5 9x7
// instance, with expected windows computed from a stored copy of each frame.
module tb_window_line_buffer;

   logic clk;
   logic rst_n;

   logic       sv   [2];
   logic       ssof [2];
   logic [7:0] spix [2];
   logic       mr   [2];

   logic         sr [2];
   logic         mv [2];
   logic         ml [2];
   logic [255:0] mw [2];

   wire         s_ready3, m_valid3, m_last3;
   wire [71:0]  m_win3;
   wire         s_ready5, m_valid5, m_last5;
   wire [199:0] m_win5;

   window_line_buffer #(.IMG_W(8), .IMG_H(6), .PIX_W(8), .KSIZE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_ready(s_ready3), .s_sof(ssof[0]),
      .s_pix(spix[0]), .m_valid(m_valid3), .m_ready(mr[0]), .m_win(m_win3), .m_last(m_last3));

   window_line_buffer #(.IMG_W(9), .IMG_H(7), .PIX_W(8), .KSIZE(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_ready(s_ready5), .s_sof(ssof[1]),
      .s_pix(spix[1]), .m_valid(m_valid5), .m_ready(mr[1]), .m_win(m_win5), .m_last(m_last5));

   assign sr[0] = s_ready3;  assign mv[0] = m_valid3;  assign ml[0] = m_last3;
   assign mw[0] = 256'(m_win3);
   assign sr[1] = s_ready5;  assign mv[1] = m_valid5;  assign ml[1] = m_last5;
   assign mw[1] = 256'(m_win5);

   typedef struct {
      logic [255:0] win;
      logic         last;
   } exp_t;

   exp_t         exp_q [2][$];
   int           img_w [2] = '{8, 9};
   int           img_h [2] = '{6, 7};
   int           ksz   [2] = '{3, 5};
   logic [7:0]   frame [2][64];
   int           fidx  [2];
   int           n_win [2];
   int           n_last[2];
   int           n_stall[2];
   logic [255:0] held  [2];
   bit           stalled_prev[2];
   bit           arm_first[2];
   logic [255:0] first_win[2];
   int           rdy_pct[2];
   bit           force_low[2];
   bit           bp_arm[2];
   int           hold_cnt[2];

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: window = KxK block of the stored frame ending at the accepted pixel
   task automatic model_accept(input int d, input logic [7:0] p, input logic sof);
      int   r, c, k, w;
      exp_t e;
      k = ksz[d];
      w = img_w[d];
      if (sof) fidx[d] = 0;
      r = fidx[d] / w;
      c = fidx[d] % w;
      frame[d][fidx[d]] = p;
      if (r >= k - 1 && c >= k - 1) begin
         e.win = '0;
         for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++)
               e.win[(i*k + j)*8 +: 8] = frame[d][(r - k + 1 + i)*w + (c - k + 1 + j)];
         e.last = (fidx[d] == w * img_h[d] - 1);
         exp_q[d].push_back(e);
      end
      fidx[d] = (fidx[d] + 1) % (w * img_h[d]);
   endtask

   // Monitor: samples on the falling edge, checks handshakes, then models acceptances
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            exp_q[d].delete();
            fidx[d] = 0;
            stalled_prev[d] = 0;
            chk("rst_m_valid", 256'(mv[d]), 256'(0));
            chk("rst_s_ready", 256'(sr[d]), 256'(1));
            chk("rst_m_win", mw[d], 256'(0));
         end else begin
            chk("valid_vs_queue", 256'(mv[d]), 256'(exp_q[d].size() != 0));
            if (stalled_prev[d]) chk("stall_win_stable", mw[d], held[d]);
            if (mv[d] && mr[d]) begin
               if (exp_q[d].size() == 0) begin
                  chk("unexpected_window", 256'(1), 256'(0));
               end else begin
                  e = exp_q[d].pop_front();
                  chk("window", mw[d], e.win);
                  chk("last", 256'(ml[d]), 256'(e.last));
               end
               n_win[d]++;
               if (ml[d]) n_last[d]++;
               if (arm_first[d]) begin
                  first_win[d] = mw[d];
                  arm_first[d] = 0;
               end
            end else if (mv[d]) begin
               chk("stall_s_ready", 256'(sr[d]), 256'(0));
               n_stall[d]++;
            end
            held[d] = mw[d];
            stalled_prev[d] = mv[d] && !mr[d];
            if (sv[d] && sr[d]) model_accept(d, spix[d], ssof[d]);
         end
      end
   end

   // Downstream ready: random, forced low, or a 5-cycle stall on the (2,2)=20 window
   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++) begin
         if (bp_arm[d] && mv[d] && mw[d][71:64] == 8'd20) begin
            bp_arm[d]   = 0;
            hold_cnt[d] = 5;
         end
         if (force_low[d]) begin
            mr[d] = 1'b0;
         end else if (hold_cnt[d] > 0) begin
            mr[d] = 1'b0;
            hold_cnt[d]--;
         end else begin
            mr[d] = ($urandom_range(99) < rdy_pct[d]);
         end
      end
   end

   task automatic send_pix(input int d, input logic [7:0] p, input logic sof, input int vpct);
      bit done  = 0;
      int guard = 0;
      while (!done) begin
         @(posedge clk); #1;
         if ($urandom_range(99) < vpct) begin
            sv[d] = 1'b1; spix[d] = p; ssof[d] = sof;
         end else begin
            sv[d] = 1'b0; ssof[d] = 1'b0; spix[d] = 8'($urandom);
         end
         @(negedge clk);
         if (sv[d] && sr[d]) done = 1;
         guard++;
         if (guard > 2000) begin
            $display("FAIL send_timeout: got no acceptance expected acceptance");
            $fatal(1, "input stalled");
         end
      end
   endtask

   task automatic idle(input int d);
      @(posedge clk); #1;
      sv[d] = 1'b0; ssof[d] = 1'b0;
   endtask

   task automatic send_frame(input int d, input int n, input int base, input bit rnd,
                             input bit sof_first, input int vpct);
      for (int i = 0; i < n; i++)
         send_pix(d, rnd ? 8'($urandom) : 8'(base + i), (i == 0) && sof_first, vpct);
      idle(d);
   endtask

   task automatic drain(input int d);
      int t = 0;
      while ((exp_q[d].size() != 0 || mv[d]) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 256'(exp_q[d].size() != 0 || mv[d]), 256'(0));
   endtask

   localparam logic [255:0] FIRST3 = 256'h12_11_10_0a_09_08_02_01_00;

   initial begin
      int bw, bl, bs;
      logic [255:0] fw;
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bw, bl, bs;
      logic [255:0] fw;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         sv[d] = 0; ssof[d] = 0; spix[d] = 0; mr[d] = 1;
         fidx[d] = 0; n_win[d] = 0; n_last[d] = 0; n_stall[d] = 0;
         held[d] = '0; stalled_prev[d] = 0; arm_first[d] = 0; first_win[d] = '0;
         rdy_pct[d] = 100; force_low[d] = 0; bp_arm[d] = 0; hold_cnt[d] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Plain ramp, K=3
      bw = n_win[0]; bl = n_last[0];
      arm_first[0] = 1;
      send_frame(0, 48, 0, 0, 1, 100);
      drain(0);
      chk("ramp_first", first_win[0], FIRST3);
      chk("ramp_count", 256'(n_win[0] - bw), 256'(24));
      chk("ramp_last", 256'(n_last[0] - bl), 256'(1));

      // Same ramp with a 5-cycle stall on the (2,2)=20 window
      bw = n_win[0]; bs = n_stall[0];
      bp_arm[0] = 1;
      send_frame(0, 48, 0, 0, 1, 100);
      drain(0);
      chk("bp_count", 256'(n_win[0] - bw), 256'(24));
      chk("bp_stall_cycles", 256'(n_stall[0] - bs), 256'(5));

      // Three random frames, random valid and ready
      bw = n_win[0]; bl = n_last[0];
      rdy_pct[0] = 50;
      send_frame(0, 144, 0, 1, 1, 50);
      drain(0);
      rdy_pct[0] = 100;
      chk("rand_count", 256'(n_win[0] - bw), 256'(72));
      chk("rand_last", 256'(n_last[0] - bl), 256'(3));

      // Aborted frame of 30 pixels, then a full ramp frame
      send_frame(0, 30, 100, 0, 1, 100);
      drain(0);
      bw = n_win[0];
      arm_first[0] = 1;
      send_frame(0, 48, 0, 0, 1, 100);
      drain(0);
      chk("abort_first", first_win[0], FIRST3);
      chk("abort_count", 256'(n_win[0] - bw), 256'(24));

      // Reset while a window is stalled
      force_low[0] = 1;
      send_frame(0, 19, 0, 0, 1, 100);
      repeat (2) @(negedge clk);
      chk("pre_reset_stalled", 256'(mv[0]), 256'(1));
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      chk("reset_valid_now", 256'(mv[0]), 256'(0));
      chk("reset_ready_now", 256'(sr[0]), 256'(1));
      @(posedge clk); #1 rst_n = 1'b1;
      force_low[0] = 0;
      bw = n_win[0]; bl = n_last[0];
      arm_first[0] = 1;
      send_frame(0, 48, 0, 0, 0, 100);
      drain(0);
      chk("post_reset_first", first_win[0], FIRST3);
      chk("post_reset_count", 256'(n_win[0] - bw), 256'(24));
      chk("post_reset_last", 256'(n_last[0] - bl), 256'(1));

      // K=5 on a 9x7 ramp
      bw = n_win[1]; bl = n_last[1];
      arm_first[1] = 1;
      send_frame(1, 63, 0, 0, 1, 100);
      drain(1);
      fw = first_win[1];
      chk("k5_count", 256'(n_win[1] - bw), 256'(15));
      chk("k5_last", 256'(n_last[1] - bl), 256'(1));
      chk("k5_first_00", 256'(fw[7:0]), 256'(0));
      chk("k5_first_44", 256'(fw[199:192]), 256'(40));

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
